// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared decode constants for the fetch stage and the control FSM.
//            It holds the instruction field positions, the opcode and
//            condition-code values, and the default reset PC.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Instruction field positions. Each field is 4 bits wide.
    localparam int unsigned OPC1_LSB  = 12;   // opCode1       IR[15:12]
    localparam int unsigned COND_LSB  = 8;    // conditionCode IR[11:8]
    localparam int unsigned OPC2_LSB  = 4;    // opCode2       IR[7:4]
    localparam int unsigned SHAMT_LSB = 0;    // shiftAmt      IR[3:0]
    localparam int unsigned RDEST_LSB = 8;    // rdest         IR[11:8]
    localparam int unsigned RSRC_LSB  = 0;    // rsrc          IR[3:0]
    localparam int unsigned FIELD_W   = 4;
    localparam int unsigned IMM_W     = 8;    // immediate     IR[7:0]

    // Primary opcodes, held in opCode1.
    typedef enum logic [3:0] {
        OP_RTYPE = 4'h0,
        OP_ANDI  = 4'h1,
        OP_ORI   = 4'h2,
        OP_XORI  = 4'h3,
        OP_MEM   = 4'h4,   // LOAD/STOR/JAL/JCOND class; opCode2 selects
        OP_ADDI  = 4'h5,
        OP_SHIFT = 4'h8,
        OP_SUBI  = 4'h9,
        OP_CMPI  = 4'hB,
        OP_BCOND = 4'hC,
        OP_MOVI  = 4'hD,
        OP_LUI   = 4'hF
    } opcode_e;

    // Secondary opcodes inside the OP_MEM class.
    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STOR  = 4'h4;
    localparam logic [3:0] EXT_JAL   = 4'h8;
    localparam logic [3:0] EXT_JCOND = 4'hC;

    // Condition codes for BCOND and JCOND.
    typedef enum logic [3:0] {
        CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
        CC_HI = 4'h4, CC_LS = 4'h5, CC_GT = 4'h6, CC_LE = 4'h7,
        CC_FS = 4'h8, CC_FC = 4'h9, CC_LO = 4'hA, CC_HS = 4'hB,
        CC_LT = 4'hC, CC_GE = 4'hD, CC_UC = 4'hE, CC_NV = 4'hF
    } cond_e;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_pc_next.sv
`default_nettype none
// ============================================================================
// Module   : pc_next
// Purpose  : Combinational next-PC selection. It takes the current PC, the
//            branch displacement, the jump target and the FSM strobes. A link
//            strobe is raised only when a JAL wins the priority order.
// Revision : 1.0 - initial release
// ============================================================================
module pc_next
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] pc_i,
    input  logic [IMM_W-1:0] disp_i,
    input  logic [WIDTH-1:0] jump_target_i,
    input  logic             pc_instruction_i,
    input  logic             branch_en_i,
    input  logic             jmp_en_i,
    input  logic             jal_en_i,
    output logic [WIDTH-1:0] pc_next_o,
    output logic [WIDTH-1:0] pc_plus1_o,
    output logic             link_take_o
);

    logic [WIDTH-1:0] disp_sext;

    // The branch displacement is sign-extended and added to the branch's own PC.
    assign disp_sext  = {{(WIDTH-IMM_W){disp_i[IMM_W-1]}}, disp_i};
    assign pc_plus1_o = pc_i + WIDTH'(1);

    // Priority is jump, then JAL, then branch, then increment. When no strobe
    // is set the PC still advances by one, which covers not-taken branches and
    // not-taken jumps.
    always_comb begin
        pc_next_o   = pc_plus1_o;
        link_take_o = 1'b0;
        if (jmp_en_i) begin
            pc_next_o = jump_target_i;
        end else if (jal_en_i) begin
            pc_next_o   = jump_target_i;
            link_take_o = 1'b1;
        end else if (branch_en_i) begin
            pc_next_o = pc_i + disp_sext;
        end else if (pc_instruction_i) begin
            pc_next_o = pc_plus1_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch and PC stage. It holds the PC, the IR, the JAL
//            link register and the fetch counter, and it splits the IR into
//            its decode fields.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               REGBITS  = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   memData,
    input  logic               nextInstruction,
    input  logic               PCEN,
    input  logic               PCinstruction,
    input  logic               BranchEN,
    input  logic               JmpEN,
    input  logic               JALEN,
    input  logic               zeroExtend,
    input  logic [WIDTH-1:0]   jumpTarget,
    output logic [WIDTH-1:0]   pc,
    output logic [WIDTH-1:0]   instr,
    output logic [3:0]         opCode1,
    output logic [3:0]         conditionCode,
    output logic [3:0]         opCode2,
    output logic [3:0]         shiftAmt,
    output logic [REGBITS-1:0] rdestAddr,
    output logic [REGBITS-1:0] rsrcAddr,
    output logic [WIDTH-1:0]   immExt,
    output logic [WIDTH-1:0]   linkAddr,
    output logic [WIDTH-1:0]   instrCount
);

    logic [WIDTH-1:0] pc_q,    pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] link_q,  link_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] pc_sel;
    logic [WIDTH-1:0] pc_plus1;
    logic             link_take;

    pc_next #(
        .WIDTH (WIDTH)
    ) u_pc_next (
        .pc_i             (pc_q),
        .disp_i           (instr_q[IMM_W-1:0]),
        .jump_target_i    (jumpTarget),
        .pc_instruction_i (PCinstruction),
        .branch_en_i      (BranchEN),
        .jmp_en_i         (JmpEN),
        .jal_en_i         (JALEN),
        .pc_next_o        (pc_sel),
        .pc_plus1_o       (pc_plus1),
        .link_take_o      (link_take)
    );

    // Next-state values. The IR load and the PC write are independent, so
    // both can take effect at the same edge.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        link_d  = link_q;
        count_d = count_q;
        if (nextInstruction) begin
            instr_d = memData;
            count_d = count_q + WIDTH'(1);
        end
        if (PCEN) begin
            pc_d = pc_sel;
            if (link_take) begin
                link_d = pc_plus1;
            end
        end
    end

    // State registers. The asynchronous reset clears them at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            link_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            link_q  <= link_d;
            count_q <= count_d;
        end
    end

    assign pc            = pc_q;
    assign instr         = instr_q;
    assign linkAddr      = link_q;
    assign instrCount    = count_q;
    assign opCode1       = instr_q[OPC1_LSB  +: FIELD_W];
    assign conditionCode = instr_q[COND_LSB  +: FIELD_W];
    assign opCode2       = instr_q[OPC2_LSB  +: FIELD_W];
    assign shiftAmt      = instr_q[SHAMT_LSB +: FIELD_W];
    assign rdestAddr     = instr_q[RDEST_LSB +: REGBITS];
    assign rsrcAddr      = instr_q[RSRC_LSB  +: REGBITS];

    // immExt follows the live zeroExtend input.
    assign immExt = zeroExtend ? {{(WIDTH-IMM_W){1'b0}}, instr_q[IMM_W-1:0]}
                               : {{(WIDTH-IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. It uses directed vectors, a
//            behavioural reference model and hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] memData = '0;
    logic        nextInstruction = 1'b0;
    logic        PCEN = 1'b0;
    logic        PCinstruction = 1'b0;
    logic        BranchEN = 1'b0;
    logic        JmpEN = 1'b0;
    logic        JALEN = 1'b0;
    logic        zeroExtend = 1'b0;
    logic [15:0] jumpTarget = '0;

    logic [15:0] pc, instr, immExt, linkAddr, instrCount;
    logic [3:0]  opCode1, conditionCode, opCode2, shiftAmt;
    logic [3:0]  rdestAddr, rsrcAddr;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.WIDTH(16), .REGBITS(4), .RESET_PC(16'h0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .memData         (memData),
        .nextInstruction (nextInstruction),
        .PCEN            (PCEN),
        .PCinstruction   (PCinstruction),
        .BranchEN        (BranchEN),
        .JmpEN           (JmpEN),
        .JALEN           (JALEN),
        .zeroExtend      (zeroExtend),
        .jumpTarget      (jumpTarget),
        .pc              (pc),
        .instr           (instr),
        .opCode1         (opCode1),
        .conditionCode   (conditionCode),
        .opCode2         (opCode2),
        .shiftAmt        (shiftAmt),
        .rdestAddr       (rdestAddr),
        .rsrcAddr        (rsrcAddr),
        .immExt          (immExt),
        .linkAddr        (linkAddr),
        .instrCount      (instrCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state updated by the rules of the stage.
    int m_pc = 0, m_instr = 0, m_link = 0, m_count = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc = 0; m_instr = 0; m_link = 0; m_count = 0;
        end else begin
            int disp;
            disp = m_instr % 256;
            if (disp >= 128) disp = disp - 256;
            if (PCEN) begin
                if (JmpEN)         m_pc = jumpTarget;
                else if (JALEN)    begin m_link = (m_pc + 1) % 65536; m_pc = jumpTarget; end
                else if (BranchEN) m_pc = (m_pc + disp + 65536) % 65536;
                else               m_pc = (m_pc + 1) % 65536;
            end
            if (nextInstruction) begin
                m_instr = memData;
                m_count = (m_count + 1) % 65536;
            end
        end
    end

    // Compare every output against the model midway between active edges.
    always @(negedge clk) begin
        int imm;
        imm = m_instr % 256;
        if (!zeroExtend && imm >= 128) imm = imm - 256;
        chk("pc",         pc,         16'(m_pc));
        chk("instr",      instr,      16'(m_instr));
        chk("linkAddr",   linkAddr,   16'(m_link));
        chk("instrCount", instrCount, 16'(m_count));
        chk("opCode1",    16'(opCode1),       16'(m_instr / 4096));
        chk("condCode",   16'(conditionCode), 16'((m_instr / 256) % 16));
        chk("opCode2",    16'(opCode2),       16'((m_instr / 16) % 16));
        chk("shiftAmt",   16'(shiftAmt),      16'(m_instr % 16));
        chk("rdestAddr",  16'(rdestAddr),     16'((m_instr / 256) % 16));
        chk("rsrcAddr",   16'(rsrcAddr),      16'(m_instr % 16));
        chk("immExt",     immExt,     16'(imm + 65536));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        nextInstruction = 0; PCEN = 0; PCinstruction = 0;
        BranchEN = 0; JmpEN = 0; JALEN = 0;
    endtask

    task automatic jump_to(input logic [15:0] t);
        PCEN = 1; JmpEN = 1; jumpTarget = t;
        step();
        clear_strobes();
    endtask

    initial begin
        #1 reset = 0;
        step(); step();
        chk("rst_pc",    pc,         16'h0000);
        chk("rst_instr", instr,      16'h0000);
        chk("rst_link",  linkAddr,   16'h0000);
        chk("rst_count", instrCount, 16'h0000);
        chk("rst_op1",   16'(opCode1), 16'h0000);
        reset = 1;

        // First fetch
        memData = 16'h5301; nextInstruction = 1;
        step();
        clear_strobes();
        chk("f_instr", instr, 16'h5301);
        chk("f_op1",   16'(opCode1), 16'h0005);
        chk("f_cc",    16'(conditionCode), 16'h0003);
        chk("f_op2",   16'(opCode2), 16'h0000);
        chk("f_sh",    16'(shiftAmt), 16'h0001);
        chk("f_count", instrCount, 16'h0001);
        chk("f_pc",    pc, 16'h0000);

        // Increment wraps from FFFF to 0000
        jump_to(16'hFFFF);
        chk("j_pc", pc, 16'hFFFF);
        PCEN = 1; PCinstruction = 1;
        step();
        clear_strobes();
        chk("wrap_pc", pc, 16'h0000);

        // IR load and PC jump at the same edge
        memData = 16'hC0FE; nextInstruction = 1;
        PCEN = 1; JmpEN = 1; jumpTarget = 16'h0010;
        step();
        clear_strobes();
        chk("both_instr", instr, 16'hC0FE);
        chk("both_pc",    pc,    16'h0010);
        chk("both_count", instrCount, 16'h0002);

        // Branch taken with displacement -2, then not taken
        PCEN = 1; BranchEN = 1;
        step();
        clear_strobes();
        chk("br_taken", pc, 16'h000E);
        jump_to(16'h0010);
        PCEN = 1;
        step();
        clear_strobes();
        chk("br_not", pc, 16'h0011);

        // JAL
        jump_to(16'h0020);
        PCEN = 1; JALEN = 1; jumpTarget = 16'h1234;
        step();
        clear_strobes();
        chk("jal_pc",   pc,       16'h1234);
        chk("jal_link", linkAddr, 16'h0021);

        // Jump has priority over JAL, so linkAddr holds
        jump_to(16'h0050);
        PCEN = 1; JmpEN = 1; JALEN = 1; jumpTarget = 16'h1234;
        step();
        clear_strobes();
        chk("jj_pc",   pc,       16'h1234);
        chk("jj_link", linkAddr, 16'h0021);

        // PCEN=0 holds the PC whatever the strobes
        JmpEN = 1; BranchEN = 1; PCinstruction = 1; jumpTarget = 16'hBEEF;
        step();
        clear_strobes();
        chk("hold_pc", pc, 16'h1234);

        // immExt follows the live zeroExtend input
        memData = 16'h5080; nextInstruction = 1;
        step();
        clear_strobes();
        zeroExtend = 1; #1;
        chk("imm_zx", immExt, 16'h0080);
        zeroExtend = 0; #1;
        chk("imm_sx", immExt, 16'hFF80);

        // Asynchronous reset in the middle of a cycle
        jump_to(16'h0042);
        chk("pre_rst_pc", pc, 16'h0042);
        #1 reset = 0;
        #1;
        chk("ar_pc",    pc,         16'h0000);
        chk("ar_instr", instr,      16'h0000);
        chk("ar_link",  linkAddr,   16'h0000);
        chk("ar_count", instrCount, 16'h0000);
        step();
        reset = 1;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
